// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive sides: FSM state
// encoding, default serial timing, and a payload-mask helper.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 10;
   localparam int DEFAULT_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Mask that keeps the low 'bits' payload bits of a byte.
   function automatic logic [7:0] data_mask(input int bits);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         m[i] = (i < bits);
      end
      return m;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter: counts 0..i_rollover_val and then wraps to 0. Synchronous
// clear has priority over counting. The flag marks the last count of a period.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_count_enable,
   input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
   output logic [NUM_CNT_BITS-1:0] o_count,
   output logic                    o_rollover_flag
);

   logic [NUM_CNT_BITS-1:0] r_count;
   logic                    w_at_end;

   assign w_at_end        = (r_count == i_rollover_val);
   assign o_rollover_flag = i_count_enable && w_at_end;
   assign o_count         = r_count;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count_enable) begin
         if (w_at_end) r_count <= '0;
         else          r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS payload bits LSB first, optional
// even-parity bit, one stop bit. Registered serial output, valid/ready input.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEFAULT_DATA_BITS,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       serial_out,
   output logic       tx_done
);

   localparam logic [3:0] BIT_LAST  = 4'(CLKS_PER_BIT - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [7:0] DATA_MASK = data_mask(DATA_BITS);
   localparam bit         HAS_PAR   = (PARITY_EN != 0);

   tx_state_e  r_state;
   logic [7:0] r_shift;
   logic [2:0] r_bit_idx;
   logic       r_parity;
   logic       r_serial;

   logic       w_handshake;
   logic       w_bit_tick;
   logic [3:0] w_bit_count;
   logic [7:0] w_masked;

   assign tx_ready    = (r_state == ST_IDLE);
   assign w_handshake = tx_valid && tx_ready;
   assign w_masked    = tx_data & DATA_MASK;
   assign serial_out  = r_serial;
   assign tx_done     = (r_state == ST_STOP) && (w_bit_count == BIT_LAST);

   // Held at zero in IDLE so every START bit gets a full period.
   flex_counter #(
      .NUM_CNT_BITS (4)
   ) u_bit_timer (
      .clk             (clk),
      .rst             (rst),
      .i_clear         (r_state == ST_IDLE),
      .i_count_enable  (r_state != ST_IDLE),
      .i_rollover_val  (BIT_LAST),
      .o_count         (w_bit_count),
      .o_rollover_flag (w_bit_tick)
   );

   // serial_out is updated on the same edge as the state, so it always shows
   // the level belonging to the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
         r_serial  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_serial <= 1'b1;
               if (w_handshake) begin
                  r_shift  <= w_masked;
                  r_parity <= ^w_masked;
                  r_state  <= ST_START;
                  r_serial <= 1'b0;
               end
            end
            ST_START: begin
               if (w_bit_tick) begin
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
                  r_serial  <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_tick) begin
                  if (r_bit_idx == DATA_LAST) begin
                     r_bit_idx <= '0;
                     if (HAS_PAR) begin
                        r_state  <= ST_PARITY;
                        r_serial <= r_parity;
                     end else begin
                        r_state  <= ST_STOP;
                        r_serial <= 1'b1;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     r_serial  <= r_shift[1];
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_tick) begin
                  r_state  <= ST_STOP;
                  r_serial <= 1'b1;
               end
            end
            ST_STOP: begin
               if (w_bit_tick) begin
                  r_state  <= ST_IDLE;
                  r_serial <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_serial <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: three parameterisations, a
// frame-level reference model, constant vector tables and corner sequences.
module tb_uart_transmitter;

   logic clk = 1'b0;
   logic rst;

   logic       v0, v1, v2;
   logic [7:0] d0, d1, d2;
   logic       r0, r1, r2;
   logic       s0, s1, s2;
   logic       dn0, dn1, dn2;

   int n_checks = 0;
   int n_fail   = 0;

   bit exp_q[$];

   typedef struct {
      logic [7:0] data;
      bit         exp_par;
   } par_vec_t;

   par_vec_t pv[6];

   always #5 clk = ~clk;

   // Defaults: 10 clocks/bit, 8 data bits, no parity
   uart_transmitter u_dut0 (
      .clk (clk), .rst (rst), .tx_valid (v0), .tx_data (d0),
      .tx_ready (r0), .serial_out (s0), .tx_done (dn0)
   );

   uart_transmitter #(.PARITY_EN (1)) u_dut1 (
      .clk (clk), .rst (rst), .tx_valid (v1), .tx_data (d1),
      .tx_ready (r1), .serial_out (s1), .tx_done (dn1)
   );

   uart_transmitter #(.CLKS_PER_BIT (2), .DATA_BITS (5), .PARITY_EN (1)) u_dut2 (
      .clk (clk), .rst (rst), .tx_valid (v2), .tx_data (d2),
      .tx_ready (r2), .serial_out (s2), .tx_done (dn2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      case (sel)
         0:       begin v0 = v; d0 = d; end
         1:       begin v1 = v; d1 = d; end
         default: begin v2 = v; d2 = d; end
      endcase
   endtask

   // Returns {tx_ready, tx_done, serial_out}
   function automatic logic [2:0] outs(input int sel);
      case (sel)
         0:       return {r0, dn0, s0};
         1:       return {r1, dn1, s1};
         default: return {r2, dn2, s2};
      endcase
   endfunction

   // Reference model: list of line levels for one frame, one entry per bit.
   function automatic void build_model(input logic [7:0] data, input int nb, input bit par);
      int ones;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(data[i]);
         ones += int'(data[i]);
      end
      if (par) exp_q.push_back(bit'(ones % 2));
      exp_q.push_back(1'b1);
   endfunction

   // Called at a negedge with the DUT idle. Sends one frame, checks every cycle
   // against exp_q, then checks the following idle cycle.
   task automatic play_frame(input int sel, input int cpb, input bit keep_valid,
                             input logic [7:0] data, input int pulse_at, input string tag);
      int len;
      len = exp_q.size() * cpb;
      check({tag, " ready_before"}, 32'(outs(sel)), 32'b101);
      drive(sel, 1'b1, data);
      @(posedge clk);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         check($sformatf("%s c%0d", tag, k), 32'(outs(sel)),
               32'({1'b0, (k == len), exp_q[(k - 1) / cpb]}));
         if (k == 1 && !keep_valid) drive(sel, 1'b0, 8'($urandom));
         if (k == 2 && keep_valid)  drive(sel, 1'b1, 8'($urandom));
         if (pulse_at != 0 && k == pulse_at)     drive(sel, 1'b1, 8'($urandom));
         if (pulse_at != 0 && k == pulse_at + 1) drive(sel, 1'b0, 8'($urandom));
      end
      @(negedge clk);
      check({tag, " idle_after"}, 32'(outs(sel)), 32'b101);
   endtask

   initial begin
      logic [9:0]  a5_line;
      logic [7:0]  rd;
      int          sel, nb, cpb, pulse;
      bit          par;

      pv[0] = '{8'h07, 1'b1};
      pv[1] = '{8'h03, 1'b0};
      pv[2] = '{8'hA5, 1'b0};
      pv[3] = '{8'hFF, 1'b0};
      pv[4] = '{8'h80, 1'b1};
      pv[5] = '{8'h00, 1'b0};

      v0 = 0; v1 = 0; v2 = 0;
      d0 = 0; d1 = 0; d2 = 0;
      rst = 1'b1;
      #1;
      check("reset dut0", 32'(outs(0)), 32'b101);
      check("reset dut1", 32'(outs(1)), 32'b101);
      check("reset dut2", 32'(outs(2)), 32'b101);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle with tx_valid low
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check($sformatf("idle50 c%0d", i), 32'(outs(0)), 32'b101);
      end

      // 8'hA5 at defaults against the literal line sequence
      a5_line = 10'b1101001010;
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(a5_line[i]);
      play_frame(0, 10, 1'b0, 8'hA5, 0, "a5");

      // Parity table on the PARITY_EN=1 instance (110-cycle frames)
      for (int t = 0; t < 6; t++) begin
         exp_q.delete();
         exp_q.push_back(1'b0);
         for (int i = 0; i < 8; i++) exp_q.push_back(pv[t].data[i]);
         exp_q.push_back(pv[t].exp_par);
         exp_q.push_back(1'b1);
         play_frame(1, 10, 1'b0, pv[t].data, 0, $sformatf("par%0d", t));
      end

      // Back-to-back with tx_valid held high
      build_model(8'h55, 8, 1'b0);
      play_frame(0, 10, 1'b1, 8'h55, 0, "b2b_55");
      build_model(8'hAA, 8, 1'b0);
      play_frame(0, 10, 1'b0, 8'hAA, 0, "b2b_aa");

      // tx_valid pulse and data change in DATA are ignored
      build_model(8'h3C, 8, 1'b0);
      play_frame(0, 10, 1'b0, 8'h3C, 45, "pulse");

      // Reset at cycle 35 of a frame
      build_model(8'hC3, 8, 1'b0);
      drive(0, 1'b1, 8'hC3);
      @(posedge clk);
      for (int k = 1; k < 35; k++) begin
         @(negedge clk);
         if (k == 1) drive(0, 1'b0, 8'h00);
         check($sformatf("rstmid c%0d", k), 32'(outs(0)),
               32'({1'b0, 1'b0, exp_q[(k - 1) / 10]}));
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid immediate", 32'(outs(0)), 32'b101);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      build_model(8'h96, 8, 1'b0);
      play_frame(0, 10, 1'b0, 8'h96, 0, "after_rst");

      // Randomized frames on all three instances
      for (int n = 0; n < 24; n++) begin
         sel = int'($urandom_range(0, 2));
         cpb = (sel == 2) ? 2 : 10;
         nb  = (sel == 2) ? 5 : 8;
         par = (sel != 0);
         rd  = 8'($urandom);
         pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(cpb + 1, cpb * (1 + nb) - 1)) : 0;
         build_model(rd, nb, par);
         play_frame(sel, cpb, 1'b0, rd, pulse, $sformatf("rnd%0d", n));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit period (legal range 2..15).
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame (legal range 5..8).
REQ-003 Parameter PARITY_EN, default 0, 1 inserts an even-parity bit between the data bits and the stop bit.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tx_valid  input  1  producer has a byte to send.
REQ-007 tx_data  input  8  payload; bits [DATA_BITS-1:0] are used, upper bits ignored.
REQ-008 tx_ready  output  1  block can accept a frame this cycle.
REQ-009 serial_out  output  1  serial line, idle high.
REQ-010 tx_done  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-011 A handshake occurs on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into an internal shift register on that edge.
REQ-012 tx_ready SHALL be 1 only in IDLE; tx_valid while tx_ready=0 SHALL be ignored, with no queuing.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on handshake; START->DATA after CLKS_PER_BIT cycles; DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after DATA_BITS bit periods; PARITY->STOP after one bit period; STOP->IDLE after one bit period.
REQ-014 serial_out SHALL be a registered output: 1 in IDLE, 0 in START, data LSB first in DATA, XOR of the latched data bits in PARITY, 1 in STOP.
REQ-015 The first START cycle on serial_out SHALL be the cycle immediately after the handshake edge (latency 1 cycle).
REQ-016 Each bit SHALL be held for exactly CLKS_PER_BIT cycles; frame length = (1+DATA_BITS+PARITY_EN+1)*CLKS_PER_BIT cycles (100 at defaults).
REQ-017 tx_done SHALL be 1 exactly during the last STOP cycle and 0 otherwise.
REQ-018 The cycle after tx_done, the FSM SHALL be in IDLE with tx_ready=1; with tx_valid held high, the next START SHALL follow after exactly one idle-high cycle.
REQ-019 Changes to tx_data after the handshake SHALL NOT affect the frame in flight.
REQ-020 The bit-period counter SHALL be cleared in IDLE, so every frame starts with a full-length START bit regardless of history.
REQ-021 The data-bit counter SHALL wrap only through the state transition, never mid-frame; no counter SHALL overflow for any legal parameter value.

Reset
REQ-022 When rst asserts, the block SHALL immediately and asynchronously enter IDLE with serial_out=1, tx_ready=1, tx_done=0, and counters and shift register at 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame, and serial_out SHALL return high in the same cycle.
REQ-024 The first handshake after rst deasserts SHALL behave as in REQ-015.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state enum and the default constants CLKS_PER_BIT=10 and DATA_BITS=8 shared with the receive side.
REQ-026 Bit-period timing SHALL use one instance of the team's existing flex_counter (4-bit, rollover at CLKS_PER_BIT, cleared in IDLE); the FSM, shift register and parity logic SHALL be local to uart_transmitter.

Verification
REQ-027 Defaults; send 8'hA5 -> serial_out = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; tx_done high only in cycle 100 after the handshake.
REQ-028 PARITY_EN=1; send 8'h07 -> parity bit = 1 and frame length = 110 cycles; send 8'h03 -> parity bit = 0.
REQ-029 tx_valid held high with 8'h55 then 8'hAA -> back-to-back frames separated by exactly one high cycle; tx_ready=0 throughout both frames except that cycle.
REQ-030 Change tx_data and pulse tx_valid during the DATA state -> frame in flight unchanged and the pulse is ignored.
REQ-031 Assert rst at cycle 35 of a frame -> serial_out=1 and tx_ready=1 immediately; the next frame after release is a full 100 cycles.
REQ-032 Idle with tx_valid=0 for 50 cycles -> serial_out stays 1, tx_done stays 0.
